rsa_job_sequencer: RTL and testbench
====================================

Name: rsa_job_sequencer

Overview:
Upstream driver for one `control` RSA instance. It replaces the procedural testbench handshaking with synthesizable RTL.
- Accepts a job (p, q, mode, message) on a valid/ready input.
- Pulses `control`'s reset_inverter, waits for inverter_finish, then pulses reset_mod_exp and waits for mod_exp_finish.
- Returns the captured msg_out on a valid/ready output.
- Two instances with opposite mode can be chained to form the encrypt→decrypt loop in hardware.

Parameters:
WIDTH, 128, prime operand width; message width is 2*WIDTH.
TIMEOUT_W, 24, width of the per-phase cycle counter.
TIMEOUT, 24'hFF_FFFF, maximum cycles allowed in any single wait phase before the job is aborted.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous active-high reset.
job_valid  in  1  job offered.
job_ready  out  1  sequencer idle and able to accept a job.
job_p  in  WIDTH  prime p.
job_q  in  WIDTH  prime q.
job_mode  in  1  encrypt_decrypt value passed to control.
job_msg  in  2*WIDTH  input message.
res_valid  out  1  result available.
res_ready  in  1  result consumed.
res_msg  out  2*WIDTH  result message; 0 on timeout.
res_timeout  out  1  qualifies res_valid: job aborted.
busy  out  1  high in any non-IDLE state.
ctl_p, ctl_q  out  WIDTH  to control p/q.
ctl_mode  out  1  to control encrypt_decrypt.
ctl_msg_in  out  2*WIDTH  to control msg_in.
ctl_reset_inverter  out  1  one-cycle start pulse.
ctl_reset_mod_exp  out  1  one-cycle start pulse.
ctl_inverter_finish  in  1  from control.
ctl_mod_exp_finish  in  1  from control.
ctl_msg_out  in  2*WIDTH  from control.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs 0, except job_ready=1.
  - Operand registers and counter cleared.
  - Asserting reset mid-job aborts the job silently; no result is produced.
- States: IDLE, INV_START, INV_WAIT, EXP_START, EXP_WAIT, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid&&job_ready, register p/q/mode/msg into the ctl_* outputs and go to INV_START.
  - ctl_* operand outputs stay stable from acceptance until the next acceptance.
- INV_START: ctl_reset_inverter=1 for exactly one cycle; clear counter; go to INV_WAIT.
- INV_WAIT, blanking: the first cycle in the state ignores ctl_inverter_finish, because finish may be stale-high from the previous job.
- INV_WAIT, from the second cycle:
  - finish=1 → EXP_START.
  - Otherwise, counter==TIMEOUT-1 → DONE with res_timeout=1 and res_msg=0.
  - Otherwise, increment counter.
- EXP_START: ctl_reset_mod_exp=1 for one cycle; clear counter; go to EXP_WAIT.
- EXP_WAIT:
  - Same blanking and timeout rules as INV_WAIT, using ctl_mod_exp_finish.
  - On finish, capture ctl_msg_out into res_msg on the same edge; go to DONE with res_timeout=0.
- DONE:
  - res_valid=1; res_msg and res_timeout are held stable while res_valid && !res_ready.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
  - Accepting a new job in that same cycle is not allowed; job_ready is 0 in DONE.
- Simultaneous events: if finish and timeout are both due in the same cycle, finish wins.
- Latency, with acceptance at edge 0:
  - ctl_reset_inverter is high in cycle 1.
  - If inverter_finish is first sampled high at edge k (k≥3), ctl_reset_mod_exp is high in cycle k+1.
  - If mod_exp_finish is first sampled high at edge m, res_valid is high from cycle m+1.
- Counter: saturates at TIMEOUT-1; no wrap.
- busy = (state != IDLE).

Decomposition:
- Package rsa_seq_pkg:
  - state enum: IDLE=0, INV_START=1, INV_WAIT=2, EXP_START=3, EXP_WAIT=4, DONE=5.
  - Default WIDTH and TIMEOUT_W constants.
- Sub-module rsa_seq_timer:
  - Ports: clear, enable, expired.
  - TIMEOUT_W-bit saturating counter with async reset.

Test Plan:
All scenarios use a stub control model: inverter_finish 5 cycles after reset_inverter, mod_exp_finish 20 cycles after reset_mod_exp, msg_out=msg_in+1, finish held high until the next pulse.
1. Single job, p=61, q=53, mode=0, msg=256'h49, res_ready tied 1 → exactly one reset_inverter and one reset_mod_exp pulse, each 1 cycle wide; res_msg=256'h4A; res_timeout=0; res_valid for 1 cycle.
2. Back-to-back jobs msg=256'hebe2596d9d then 256'h14c5e21a9c2dc600, with stale finish high from job 1 → job 2 waits its full 5/20 cycles (blanking honored); results are msg+1 in order.
3. Output backpressure: res_ready held 0 for 10 cycles → res_valid, res_msg and res_timeout stay stable; job_ready=0 throughout; IDLE is reached one cycle after res_ready rises.
4. Stub never raises mod_exp_finish, TIMEOUT=16 → res_valid with res_timeout=1 and res_msg=0, 18 cycles after the reset_mod_exp pulse.
5. reset asserted during EXP_WAIT → all outputs 0 and job_ready=1 immediately (asynchronous); no res_valid ever appears for the aborted job.
6. Chained pair, mode 0 then 1, using the real control with p=8475698667747010771 and q=11297384090418420749, msg=256'hebe2596d9d → second sequencer's res_msg=256'hebe2596d9d.

Source files
------------

// File: rtl/rsa_seq_pkg.sv
// Shared types and defaults for the RSA job sequencer.
//   seq_state_e     : sequencer FSM state encoding
//   DefaultWidth    : default prime operand width (message is twice this)
//   DefaultTimeoutW : default width of the per-phase wait counter
package rsa_seq_pkg;

    localparam int unsigned DefaultWidth    = 128;
    localparam int unsigned DefaultTimeoutW = 24;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StInvStart = 3'd1,
        StInvWait  = 3'd2,
        StExpStart = 3'd3,
        StExpWait  = 3'd4,
        StDone     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/rsa_seq_timer.sv
// Saturating per-phase wait counter.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : force the count to zero (takes priority over enable)
//   enable     : advance the count by one, stopping at TIMEOUT-1
//   expired    : count has reached TIMEOUT-1
module rsa_seq_timer
    import rsa_seq_pkg::*;
#(
    parameter int unsigned          TIMEOUT_W = DefaultTimeoutW,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = {TIMEOUT_W{1'b1}}
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] One  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] Last = TIMEOUT - One;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + One;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Drives one RSA `control` instance through a complete job:
// accept (p, q, mode, msg) -> pulse reset_inverter -> wait inverter_finish ->
// pulse reset_mod_exp -> wait mod_exp_finish -> return msg_out.
//   job_*   : job input, valid/ready
//   res_*   : result output, valid/ready; res_timeout flags an aborted job (res_msg = 0)
//   busy    : any state other than idle
//   ctl_*   : operands, start pulses and completion inputs of the control block
module rsa_job_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int unsigned          WIDTH     = DefaultWidth,
    parameter int unsigned          TIMEOUT_W = DefaultTimeoutW,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = {TIMEOUT_W{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [WIDTH-1:0]     job_p,
    input  logic [WIDTH-1:0]     job_q,
    input  logic                 job_mode,
    input  logic [2*WIDTH-1:0]   job_msg,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_msg,
    output logic                 res_timeout,
    output logic                 busy,
    output logic [WIDTH-1:0]     ctl_p,
    output logic [WIDTH-1:0]     ctl_q,
    output logic                 ctl_mode,
    output logic [2*WIDTH-1:0]   ctl_msg_in,
    output logic                 ctl_reset_inverter,
    output logic                 ctl_reset_mod_exp,
    input  logic                 ctl_inverter_finish,
    input  logic                 ctl_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   ctl_msg_out
);

    seq_state_e           state_q, state_d;
    logic                 blank_q, blank_d;
    logic [2*WIDTH-1:0]   res_msg_q, res_msg_d;
    logic                 res_timeout_q, res_timeout_d;
    logic [WIDTH-1:0]     ctl_p_q, ctl_q_q;
    logic                 ctl_mode_q;
    logic [2*WIDTH-1:0]   ctl_msg_q;
    logic                 load_job;
    logic                 timer_clear, timer_enable, timer_expired;

    rsa_seq_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d            = state_q;
        blank_d            = 1'b0;
        res_msg_d          = res_msg_q;
        res_timeout_d      = res_timeout_q;
        load_job           = 1'b0;
        timer_clear        = 1'b0;
        timer_enable       = 1'b0;
        job_ready          = 1'b0;
        res_valid          = 1'b0;
        ctl_reset_inverter = 1'b0;
        ctl_reset_mod_exp  = 1'b0;

        unique case (state_q)
            StIdle: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    load_job = 1'b1;
                    state_d  = StInvStart;
                end
            end
            StInvStart: begin
                ctl_reset_inverter = 1'b1;
                timer_clear        = 1'b1;
                blank_d            = 1'b1;
                state_d            = StInvWait;
            end
            StInvWait: begin
                // First cycle after the pulse: finish may still be high from the last job.
                if (!blank_q) begin
                    if (ctl_inverter_finish) begin
                        state_d = StExpStart;
                    end else if (timer_expired) begin
                        state_d       = StDone;
                        res_msg_d     = '0;
                        res_timeout_d = 1'b1;
                    end else begin
                        timer_enable = 1'b1;
                    end
                end
            end
            StExpStart: begin
                ctl_reset_mod_exp = 1'b1;
                timer_clear       = 1'b1;
                blank_d           = 1'b1;
                state_d           = StExpWait;
            end
            StExpWait: begin
                if (!blank_q) begin
                    if (ctl_mod_exp_finish) begin
                        state_d       = StDone;
                        res_msg_d     = ctl_msg_out;
                        res_timeout_d = 1'b0;
                    end else if (timer_expired) begin
                        state_d       = StDone;
                        res_msg_d     = '0;
                        res_timeout_d = 1'b1;
                    end else begin
                        timer_enable = 1'b1;
                    end
                end
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            blank_q       <= 1'b0;
            res_msg_q     <= '0;
            res_timeout_q <= 1'b0;
            ctl_p_q       <= '0;
            ctl_q_q       <= '0;
            ctl_mode_q    <= 1'b0;
            ctl_msg_q     <= '0;
        end else begin
            state_q       <= state_d;
            blank_q       <= blank_d;
            res_msg_q     <= res_msg_d;
            res_timeout_q <= res_timeout_d;
            if (load_job) begin
                ctl_p_q    <= job_p;
                ctl_q_q    <= job_q;
                ctl_mode_q <= job_mode;
                ctl_msg_q  <= job_msg;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign res_msg     = res_msg_q;
    assign res_timeout = res_timeout_q;
    assign ctl_p       = ctl_p_q;
    assign ctl_q       = ctl_q_q;
    assign ctl_mode    = ctl_mode_q;
    assign ctl_msg_in  = ctl_msg_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer with a stub control block: finish rises D cycles after
// its start pulse, stays high until two cycles after the next pulse, msg_out = msg_in + 1.
// Expected result timing is derived from the acceptance cycle and the stub delays.
module tb_rsa_job_sequencer;

    localparam int unsigned W  = 128;
    localparam int unsigned TW = 24;
    localparam int          T  = 24;
    localparam int          NEVER = 1000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [W-1:0]     job_p = '0, job_q = '0;
    logic             job_mode = 1'b0;
    logic [2*W-1:0]   job_msg = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [2*W-1:0]   res_msg;
    logic             res_timeout;
    logic             busy;
    logic [W-1:0]     ctl_p, ctl_q;
    logic             ctl_mode;
    logic [2*W-1:0]   ctl_msg_in;
    logic             ctl_reset_inverter, ctl_reset_mod_exp;
    logic             ctl_inverter_finish = 1'b0, ctl_mod_exp_finish = 1'b0;
    logic [2*W-1:0]   ctl_msg_out = '0;

    rsa_job_sequencer #(
        .WIDTH     (W),
        .TIMEOUT_W (TW),
        .TIMEOUT   (24'd24)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .job_p               (job_p),
        .job_q               (job_q),
        .job_mode            (job_mode),
        .job_msg             (job_msg),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_msg             (res_msg),
        .res_timeout         (res_timeout),
        .busy                (busy),
        .ctl_p               (ctl_p),
        .ctl_q               (ctl_q),
        .ctl_mode            (ctl_mode),
        .ctl_msg_in          (ctl_msg_in),
        .ctl_reset_inverter  (ctl_reset_inverter),
        .ctl_reset_mod_exp   (ctl_reset_mod_exp),
        .ctl_inverter_finish (ctl_inverter_finish),
        .ctl_mod_exp_finish  (ctl_mod_exp_finish),
        .ctl_msg_out         (ctl_msg_out)
    );

    always #5 clk = ~clk;

    // cyc == n during cycle n, i.e. between edge n-1 and edge n.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- stub control block ----------------
    int inv_delay = 5, exp_delay = 20;
    int inv_pulses = 0, exp_pulses = 0;
    int last_inv = -1, last_exp = -1;
    int inv_due = 0, exp_due = 0;
    int inv_clr = 0, exp_clr = 0;
    bit inv_armed = 0, exp_armed = 0;

    always @(negedge clk) begin
        if (ctl_reset_inverter) begin
            inv_pulses++;
            last_inv  = cyc;
            inv_clr   = 2;
            inv_armed = (inv_delay < NEVER);
            inv_due   = cyc + inv_delay;
        end else if (inv_clr > 0) begin
            inv_clr--;
            if (inv_clr == 0) ctl_inverter_finish = 1'b0;
        end
        if (inv_armed && cyc == inv_due) begin
            ctl_inverter_finish = 1'b1;
            inv_armed = 0;
        end
        if (ctl_reset_mod_exp) begin
            exp_pulses++;
            last_exp  = cyc;
            exp_clr   = 2;
            exp_armed = (exp_delay < NEVER);
            exp_due   = cyc + exp_delay;
        end else if (exp_clr > 0) begin
            exp_clr--;
            if (exp_clr == 0) ctl_mod_exp_finish = 1'b0;
        end
        if (exp_armed && cyc == exp_due) begin
            ctl_mod_exp_finish = 1'b1;
            exp_armed = 0;
        end
        ctl_msg_out = ctl_msg_in + 256'd1;
    end

    // ---------------- reference expectations for the job in flight ----------------
    logic [W-1:0]   e_p, e_q;
    logic           e_mode;
    logic [2*W-1:0] e_msg_in, e_res;
    logic           e_to, e_has_exp;
    int             e_inv_pulse, e_exp_pulse, e_done, inv0, exp0;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic offer(input logic [W-1:0] p, input logic [W-1:0] q, input logic mode,
                         input logic [2*W-1:0] msg, input int d_inv, input int d_exp);
        int acc;
        inv_delay = d_inv;
        exp_delay = d_exp;
        check_eq("job_ready_idle", job_ready, 1);
        job_p = p; job_q = q; job_mode = mode; job_msg = msg; job_valid = 1'b1;
        acc  = cyc;
        inv0 = inv_pulses;
        exp0 = exp_pulses;
        @(negedge clk);
        // Scramble the bus so operands held by the DUT must come from the captured copy.
        job_valid = 1'b0;
        job_p = rand256(); job_q = rand256(); job_msg = rand256(); job_mode = ~mode;
        e_p = p; e_q = q; e_mode = mode; e_msg_in = msg;
        e_inv_pulse = acc + 1;
        if (d_inv > T + 1) begin
            e_has_exp = 1'b0; e_exp_pulse = -1;
            e_done = e_inv_pulse + T + 2; e_to = 1'b1; e_res = '0;
        end else begin
            e_has_exp   = 1'b1;
            e_exp_pulse = e_inv_pulse + d_inv + 1;
            if (d_exp > T + 1) begin
                e_done = e_exp_pulse + T + 2; e_to = 1'b1; e_res = '0;
            end else begin
                e_done = e_exp_pulse + d_exp + 1; e_to = 1'b0; e_res = msg + 256'd1;
            end
        end
    endtask

    task automatic collect(input int hold);
        int budget = 200;
        logic [2*W-1:0] m0;
        logic t0;
        while (!res_valid && budget > 0) begin
            if (job_ready || !busy) check_eq("busy_while_running", {job_ready, busy}, 2'b01);
            @(negedge clk);
            budget--;
        end
        check_eq("res_valid_arrives", res_valid, 1);
        if (!res_valid) return;
        check_eq("done_cycle", cyc, e_done);
        check_eq("res_msg", res_msg, e_res);
        check_eq("res_timeout", res_timeout, e_to);
        check_eq("inv_pulse_count", inv_pulses - inv0, 1);
        check_eq("inv_pulse_cycle", last_inv, e_inv_pulse);
        check_eq("exp_pulse_count", exp_pulses - exp0, e_has_exp ? 1 : 0);
        if (e_has_exp) check_eq("exp_pulse_cycle", last_exp, e_exp_pulse);
        check_eq("ctl_operands", {ctl_p, ctl_q, ctl_mode}, {e_p, e_q, e_mode});
        check_eq("ctl_msg_in", ctl_msg_in, e_msg_in);
        check_eq("job_ready_done", job_ready, 0);
        m0 = res_msg;
        t0 = res_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", {res_valid, job_ready}, 2'b10);
            check_eq("hold_msg", res_msg, m0);
            check_eq("hold_timeout", res_timeout, t0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("idle_after_ready", {res_valid, job_ready, busy}, 3'b010);
    endtask

    task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic mode,
                           input logic [2*W-1:0] msg, input int d_inv, input int d_exp,
                           input int hold);
        offer(p, q, mode, msg, d_inv, d_exp);
        collect(hold);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int seen;
        @(negedge clk);
        check_eq("reset_outputs", {job_ready, res_valid, busy, ctl_reset_inverter,
                 ctl_reset_mod_exp, res_timeout}, 6'b100000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single job, then back-to-back jobs with stale finish from the previous one.
        run_job(128'd61, 128'd53, 1'b0, 256'h49, 5, 20, 0);
        run_job(128'd61, 128'd53, 1'b0, 256'hebe2596d9d, 5, 20, 0);
        run_job(128'd61, 128'd53, 1'b1, 256'h14c5e21a9c2dc600, 5, 20, 0);
        // Output backpressure.
        run_job(rand256(), rand256(), 1'b0, rand256(), 5, 20, 10);
        // mod_exp never finishes; inverter never finishes.
        run_job(rand256(), rand256(), 1'b1, rand256(), 5, NEVER, 2);
        run_job(rand256(), rand256(), 1'b0, rand256(), NEVER, 20, 1);
        // Finish arrives exactly when the timeout is due (finish wins), and one cycle later.
        run_job(rand256(), rand256(), 1'b0, rand256(), T + 1, T + 1, 0);
        run_job(rand256(), rand256(), 1'b1, rand256(), T + 2, 3, 0);
        run_job(rand256(), rand256(), 1'b0, rand256(), 2, T + 2, 0);
        run_job(rand256(), rand256(), 1'b1, rand256(), 2, 2, 0);

        // Reset during EXP_WAIT aborts silently.
        offer(rand256(), rand256(), 1'b0, rand256(), 5, NEVER);
        budget = 100;
        while (cyc < e_exp_pulse + 3 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("async_reset_ctl", {job_ready, busy, res_valid, res_timeout,
                 ctl_reset_inverter, ctl_reset_mod_exp, ctl_mode}, 7'b1000000);
        check_eq("async_reset_ops", {ctl_p, ctl_q}, 256'd0);
        check_eq("async_reset_msgs", ctl_msg_in | res_msg, 256'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * T + 10; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check_eq("no_result_after_abort", seen, 0);

        // Randomized jobs around the timeout boundary.
        for (int n = 0; n < 14; n++) begin
            int di, de;
            di = (($urandom_range(0, 7)) == 0) ? NEVER : int'($urandom_range(2, T + 3));
            de = (($urandom_range(0, 7)) == 0) ? NEVER : int'($urandom_range(2, T + 3));
            run_job(rand256(), rand256(), 1'($urandom_range(0, 1)), rand256(), di, de,
                    int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
